// File: rtl/wbuart_arbiter.sv
// wbuart_arbiter: round-robin Wishbone classic arbiter sharing one wbuart slave port among NUM_MASTERS masters.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_m_* packed per-master cyc/stb/we/addr/data;
// o_m_ack/o_m_err routed to the granted master only; o_m_data read data broadcast; o_grant registered one-hot;
// o_s_* muxed bus to the slave; i_s_ack/i_s_err/i_s_data slave response.
// Optional: define ARB_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES strobed cycles without ack/err.
module wbuart_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_MASTERS-1:0]   i_m_cyc,
    input  logic [NUM_MASTERS-1:0]   i_m_stb,
    input  logic [NUM_MASTERS-1:0]   i_m_we,
    input  logic [4*NUM_MASTERS-1:0] i_m_addr,
    input  logic [8*NUM_MASTERS-1:0] i_m_data,
    output logic [NUM_MASTERS-1:0]   o_m_ack,
    output logic [NUM_MASTERS-1:0]   o_m_err,
    output logic [7:0]               o_m_data,
    output logic [NUM_MASTERS-1:0]   o_grant,
    output logic                     o_s_cyc,
    output logic                     o_s_stb,
    output logic                     o_s_we,
    output logic [3:0]               o_s_addr,
    output logic [7:0]               o_s_data,
    input  logic                     i_s_ack,
    input  logic                     i_s_err,
    input  logic [7:0]               i_s_data
);
    localparam int PW = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE = 1;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] last, g, pick, cand;
    logic [NUM_MASTERS-1:0] req;
    logic found, busy, to_hit;

    assign req  = i_m_cyc & i_m_stb;
    assign busy = state == BUSY;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign to_hit = busy && cnt == CW'(TIMEOUT_CYCLES);
    // Held at zero while idle, so every grant starts counting from zero.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            cnt <= '0;
        else if (!busy || i_s_ack || i_s_err)
            cnt <= '0;
        else if (o_s_stb)
            cnt <= cnt + 1'b1;
`else
    assign to_hit = 1'b0;
`endif

    // Round-robin search starting just after the last granted master.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = PW'((int'(last) + i) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state   <= IDLE;
            o_grant <= '0;
            last    <= PW'(NUM_MASTERS - 1);
            g       <= '0;
        end else begin
            state <= state_nxt;
            if (!busy && found) begin
                g       <= pick;
                o_grant <= ONE << pick;
            end else if (busy && state_nxt == IDLE) begin
                last    <= g;
                o_grant <= '0;
            end
        end

    always_comb
        state_nxt = busy ? ((!i_m_cyc[g] || to_hit) ? IDLE : BUSY) : (found ? BUSY : IDLE);

    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_addr = '0;
        o_s_data = '0;
        o_m_ack  = '0;
        o_m_err  = '0;
        for (int k = 0; k < NUM_MASTERS; k++)
            if (busy && g == PW'(k)) begin
                o_s_cyc    = i_m_cyc[k] & ~to_hit;
                o_s_stb    = i_m_cyc[k] & i_m_stb[k] & ~to_hit;
                o_s_we     = i_m_we[k];
                o_s_addr   = i_m_addr[4*k +: 4];
                o_s_data   = i_m_data[8*k +: 8];
                o_m_ack[k] = i_s_ack;
                o_m_err[k] = i_s_err | to_hit;
            end
        // Read data passes straight through, but reads 0 while reset is held.
        o_m_data = i_rst_n ? i_s_data : '0;
    end
endmodule

// File: tb/tb_wbuart_arbiter.sv
// tb_wbuart_arbiter: directed bench for wbuart_arbiter with a per-cycle reference model.
module tb_wbuart_arbiter;
    localparam int N  = 2;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] cyc = '0, stb = '0, we = '0;
    logic [4*N-1:0] addr = '0;
    logic [8*N-1:0] mdat = '0;
    logic s_ack = 1'b0, s_err = 1'b0;
    logic [7:0] s_dat = 8'h5A;
    logic [N-1:0] o_m_ack, o_m_err, o_grant;
    logic [7:0] o_m_data, o_s_data;
    logic o_s_cyc, o_s_stb, o_s_we;
    logic [3:0] o_s_addr;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    wbuart_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_cyc(cyc), .i_m_stb(stb), .i_m_we(we), .i_m_addr(addr), .i_m_data(mdat),
        .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_data(o_m_data), .o_grant(o_grant),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_ack(s_ack), .i_s_err(s_err), .i_s_data(s_dat)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who was served last, strobed cycles since last response.
    int owner = -1, last = N - 1, cnt = 0;

    function automatic bit hit();
        return TEN && owner >= 0 && cnt == TO;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner = -1;
            last  = N - 1;
            cnt   = 0;
        end else if (owner < 0) begin
            for (int d = 1; d <= N; d++) begin
                int k;
                k = (last + d) % N;
                if (owner < 0 && cyc[k] && stb[k]) begin
                    owner = k;
                    cnt   = 0;
                end
            end
        end else if (!cyc[owner] || hit()) begin
            last  = owner;
            owner = -1;
        end else if (s_ack || s_err)
            cnt = 0;
        else if (stb[owner])
            cnt++;

    always @(negedge clk) begin
        logic [N-1:0] eg, ea, ee;
        bit h;
        h  = hit();
        eg = '0;
        ea = '0;
        ee = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            ea[owner] = s_ack;
            ee[owner] = s_err | h;
            chk("s_cyc_stb", 32'({o_s_cyc, o_s_stb}), 32'({cyc[owner] & ~h, cyc[owner] & stb[owner] & ~h}));
            chk("s_we_addr_data", 32'({o_s_we, o_s_addr, o_s_data}),
                32'({we[owner], addr[4*owner +: 4], mdat[8*owner +: 8]}));
        end else
            chk("s_cyc_stb_idle", 32'({o_s_cyc, o_s_stb}), 32'(0));
        if (!rst_n)
            chk("s_bus_in_reset", 32'({o_s_we, o_s_addr, o_s_data}), 32'(0));
        chk("grant", 32'(o_grant), 32'(eg));
        chk("m_ack", 32'(o_m_ack), 32'(ea));
        chk("m_err", 32'(o_m_err), 32'(ee));
        chk("m_data", 32'(o_m_data), rst_n ? 32'(s_dat) : 32'(0));
    end

    // Slave: answers one cycle after it sees a strobe, unless muted.
    logic mute = 1'b0, err_mode = 1'b0, spur = 1'b0, stb_seen = 1'b0;
    always @(negedge clk) stb_seen = o_s_stb && !s_ack && !s_err && !mute;
    always @(posedge clk) begin
        #1;
        s_ack = (stb_seen && !err_mode) || spur;
        s_err = stb_seen && err_mode;
    end

    logic [N-1:0] order[$];
    logic [N-1:0] prev_g = '0;
    always @(negedge clk) begin
        if (o_grant != prev_g && o_grant != '0) order.push_back(o_grant);
        prev_g = o_grant;
    end

    logic [7:0] rd[N];
    logic [N-1:0] r_ack[N], r_err[N];

    task automatic access(input int m, input bit w, input logic [3:0] a, input logic [7:0] d, input bit drop);
        int t;
        cyc[m] = 1'b1;
        stb[m] = 1'b1;
        we[m] = w;
        addr[4*m +: 4] = a;
        mdat[8*m +: 8] = d;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(o_m_ack[m] || o_m_err[m]) && t < 200);
        chk($sformatf("access_resp_m%0d", m), 32'(o_m_ack[m] | o_m_err[m]), 32'(1));
        rd[m] = o_m_data;
        r_ack[m] = o_m_ack;
        r_err[m] = o_m_err;
        @(posedge clk); #1;
        stb[m] = 1'b0;
        if (drop) cyc[m] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t;
        repeat (2) @(posedge clk); #1;
        chk("reset_grant", 32'(o_grant), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        order.delete();
        fork
            begin access(0, 1'b0, 4'h0, 8'h00, 1'b1); access(0, 1'b0, 4'h0, 8'h00, 1'b1); end
            begin access(1, 1'b0, 4'h0, 8'h00, 1'b1); access(1, 1'b0, 4'h0, 8'h00, 1'b1); end
        join
        chk("contention_count", 32'(order.size()), 32'(4));
        chk("contention_g0", 32'(order[0]), 32'(2'b01));
        chk("contention_g1", 32'(order[1]), 32'(2'b10));
        chk("contention_g2", 32'(order[2]), 32'(2'b01));
        chk("contention_g3", 32'(order[3]), 32'(2'b10));
        chk("contention_rd0", 32'(rd[0]), 32'(8'h5A));
        chk("contention_rd1", 32'(rd[1]), 32'(8'h5A));

        fork
            access(0, 1'b1, 4'h4, 8'h41, 1'b1);
            begin
                @(negedge clk);
                chk("single_grant_c0", 32'(o_grant), 32'(0));
                @(negedge clk);
                chk("single_grant_c1", 32'(o_grant), 32'(2'b01));
                chk("single_stb", 32'(o_s_stb), 32'(1));
                chk("single_addr", 32'(o_s_addr), 32'(4'h4));
                chk("single_data", 32'(o_s_data), 32'(8'h41));
                @(negedge clk);
                chk("single_ack", 32'(o_m_ack), 32'(2'b01));
            end
        join

        order.delete();
        fork
            begin
                access(1, 1'b0, 4'h0, 8'h00, 1'b0);
                access(1, 1'b1, 4'h4, 8'h22, 1'b0);
                access(1, 1'b0, 4'h8, 8'h00, 1'b1);
            end
            begin @(posedge clk); #1; access(0, 1'b0, 4'h0, 8'h00, 1'b1); end
        join
        chk("lock_count", 32'(order.size()), 32'(2));
        chk("lock_first", 32'(order[0]), 32'(2'b10));
        chk("lock_second", 32'(order[1]), 32'(2'b01));

        err_mode = 1'b1;
        access(1, 1'b0, 4'hC, 8'h00, 1'b1);
        err_mode = 1'b0;
        chk("err_routed", 32'(r_err[1]), 32'(2'b10));
        chk("err_no_ack", 32'(r_ack[1]), 32'(0));

        spur = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        chk("spurious_ack_ignored", 32'(o_m_ack), 32'(0));
        spur = 1'b0;
        @(posedge clk); #1;

        mute = 1'b1;
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        repeat (3) @(posedge clk); #3;
        chk("pre_reset_grant", 32'(o_grant), 32'(2'b10));
        rst_n = 1'b0;
        #1;
        chk("reset_mid_grant", 32'(o_grant), 32'(0));
        chk("reset_mid_s_cyc_stb", 32'({o_s_cyc, o_s_stb}), 32'(0));
        cyc = '0;
        stb = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mute = 1'b0;
        order.delete();
        fork
            access(0, 1'b0, 4'h0, 8'h00, 1'b1);
            access(1, 1'b0, 4'h0, 8'h00, 1'b1);
        join
        chk("post_reset_first", 32'(order[0]), 32'(2'b01));

        mute = 1'b1;
        cyc[0] = 1'b1;
        stb[0] = 1'b1;
`ifdef ARB_TIMEOUT_EN
        n = 0;
        t = 0;
        do begin
            @(negedge clk);
            if (o_s_stb) n++;
            t++;
        end while (!o_m_err[0] && t < 100);
        chk("timeout_err", 32'(o_m_err), 32'(2'b01));
        chk("timeout_stb_low", 32'(o_s_stb), 32'(0));
        chk("timeout_stb_cycles", 32'(n), 32'(TO));
        @(negedge clk);
        chk("timeout_idle", 32'(o_grant), 32'(0));
        chk("timeout_err_one_cycle", 32'(o_m_err), 32'(0));
        @(posedge clk); #1;
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        mute = 1'b0;
`else
        repeat (101) @(negedge clk);
        chk("no_timeout_grant", 32'(o_grant), 32'(2'b01));
        chk("no_timeout_stb", 32'(o_s_stb), 32'(1));
        chk("no_timeout_err", 32'(o_m_err), 32'(0));
        @(posedge clk); #1;
        mute = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_m_ack[0] && t < 10);
        chk("late_ack", 32'(o_m_ack), 32'(2'b01));
        @(posedge clk); #1;
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        n = t;
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wbuart_arbiter.md
Name: wbuart_arbiter

Overview:
- Round-robin Wishbone (classic) arbiter that shares one wbuart slave port (8-bit data, 4-bit address) between NUM_MASTERS requesters, e.g. CPU core and debug bridge.
- Sits between the masters and the UART register block.
- Grants one master at a time and holds the grant for that master's whole cyc (bus lock).
- Routes ack/err only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- TIMEOUT_CYCLES, 64, cycles without slave ack/err before abort (used only with ARB_TIMEOUT_EN).

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_m_cyc  input  NUM_MASTERS  per-master cyc.
- i_m_stb  input  NUM_MASTERS  per-master stb.
- i_m_we  input  NUM_MASTERS  per-master write enable.
- i_m_addr  input  4*NUM_MASTERS  per-master address; master k at bits [4k+3:4k].
- i_m_data  input  8*NUM_MASTERS  per-master write data; master k at bits [8k+7:8k].
- o_m_ack  output  NUM_MASTERS  per-master ack.
- o_m_err  output  NUM_MASTERS  per-master err.
- o_m_data  output  8  read data, broadcast to all masters (valid for the acked master).
- o_grant  output  NUM_MASTERS  one-hot current grant, registered.
- o_s_cyc, o_s_stb, o_s_we  output  1 each  to slave.
- o_s_addr  output  4  to slave.
- o_s_data  output  8  to slave.
- i_s_ack, i_s_err  input  1 each  from slave.
- i_s_data  input  8  from slave.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=IDLE; o_grant=0; last-grant pointer=NUM_MASTERS-1, so master 0 has first priority.
  - All slave and master outputs read 0 while in reset.
- States: IDLE, BUSY.
- IDLE:
  - A request is i_m_cyc[k]&i_m_stb[k].
  - Search starts at (last+1) mod NUM_MASTERS and wraps; the first requester found is registered into o_grant and the FSM moves to BUSY.
  - Arbitration latency is one cycle. Slave cyc/stb are 0 in IDLE.
  - With no requests, the FSM stays in IDLE.
- BUSY with granted master g:
  - o_s_cyc=i_m_cyc[g], o_s_stb=i_m_cyc[g]&i_m_stb[g]; we/addr/data are muxed from g combinationally.
  - o_m_ack[g]=i_s_ack and o_m_err[g]=i_s_err, combinational. Other masters get 0.
  - o_m_data=i_s_data always.
- Lock: the grant holds while i_m_cyc[g]=1, including multiple stb phases and idle gaps between them.
- Release: when i_m_cyc[g]=0, next state is IDLE, last<=g, o_grant<=0. The minimum one idle cycle between grants is required, so a new arbitration always follows.
- Simultaneous requests: strict round-robin. A master cannot win twice in a row while another master is requesting in IDLE.
- Masters not granted see no ack/err and must keep holding cyc/stb. The arbiter never drops a pending request.
- Ack or err arriving in IDLE (spurious) is ignored and not routed to any master.
- Widths: all muxes are exact-width with no extension; the pointer is clog2(NUM_MASTERS) bits and wraps modulo NUM_MASTERS.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on grant and on each i_s_ack|i_s_err, and increments each BUSY cycle with o_s_stb=1.
  - When it reaches TIMEOUT_CYCLES, the arbiter drives o_m_err[g]=1 for exactly one cycle, forces o_s_cyc/o_s_stb to 0 from that cycle, and enters IDLE on the next edge.
  - It updates last<=g, even if master g keeps cyc high. A master still holding cyc re-arbitrates normally.
- Not defined: no counter exists, and BUSY waits indefinitely for the slave.

Test Plan:
- Single request: m0 requests at cycle 0 to addr 4'h4, data 8'h41, we=1. Expected: o_grant=2'b01 at cycle 1, o_s_stb=1 with addr 4'h4 and data 8'h41, and the slave ack in cycle 2 appears only on o_m_ack[0].
- Contention: m0 and m1 request continuously, each dropping cyc after one ack. Expected: grants alternate m0, m1, m0, m1 with one IDLE cycle between grants; read data 8'h5A from the slave reaches the acked master.
- Lock: m1 holds cyc through three stb phases (status read, then write 4'h4, then read 4'h8) while m0 requests. Expected: m0 gets no grant until m1 drops cyc; then o_grant=2'b01 one cycle later.
- Error passthrough: the slave returns i_s_err to m1's access at addr 4'hC. Expected: o_m_err[1]=1, o_m_ack=0, and m0 outputs stay 0.
- Reset mid-operation: assert i_rst_n=0 during BUSY (m1 granted). Expected: o_grant and o_s_cyc/stb go to 0 immediately; after release, m0 is granted first when both masters request.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: the slave never acks. Expected: after 8 stb cycles, a one-cycle o_m_err[g]=1, o_s_stb=0, and the FSM back in IDLE. Without the macro, the FSM stays in BUSY for 100 cycles.
